// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the imem loader.
// The loader side uses the slave modport; the source/memory side uses master.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a framed little-endian byte stream (16-bit word count + words) into
// instruction memory from address 0, holding fetch until the image is complete.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            fetch_hold,
  output logic            done,
  output logic            err,
  output logic [ADDR_WIDTH:0] words_loaded
);
  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, DATA, FLUSH, DONE, ERR
  } state_t;

  state_t                state;
  logic [15:0]           count;
  logic [1:0]            byte_idx;
  logic [23:0]           word_buf;
  logic [ADDR_WIDTH-1:0] waddr;

  logic        take;
  logic [15:0] hdr_count;
  logic        last_word;

  assign take      = bus.in_valid && bus.in_ready;
  assign hdr_count = {bus.in_data, count[7:0]};
  // words_loaded still holds the pre-increment value when the final byte lands
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_waddr <= '0;
      bus.mem_wdata <= '0;
      fetch_hold    <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
      words_loaded  <= '0;
      count         <= '0;
      byte_idx      <= '0;
      word_buf      <= '0;
      waddr         <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR0;
            bus.in_ready <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            fetch_hold   <= 1'b1;
            words_loaded <= '0;
          end
        end
        HDR0: begin
          if (take) begin
            count[7:0] <= bus.in_data;
            state      <= HDR1;
          end
        end
        HDR1: begin
          if (take) begin
            count[15:8] <= bus.in_data;
            if (hdr_count == 16'd0) begin
              state        <= DONE;
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
              fetch_hold   <= 1'b0;
            end else if (32'(hdr_count) > DEPTH) begin
              state        <= ERR;
              bus.in_ready <= 1'b0;
              err          <= 1'b1;
            end else begin
              state    <= DATA;
              byte_idx <= '0;
              waddr    <= '0;
            end
          end
        end
        DATA: begin
          if (take) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= bus.in_data;
              2'd1: word_buf[15:8]  <= bus.in_data;
              2'd2: word_buf[23:16] <= bus.in_data;
              default: begin
                bus.mem_wdata <= {bus.in_data, word_buf};
                bus.mem_waddr <= waddr;
                bus.mem_we    <= 1'b1;
                waddr         <= waddr + ADDR_WIDTH'(1);
                words_loaded  <= words_loaded + (ADDR_WIDTH+1)'(1);
                if (last_word) begin
                  state        <= FLUSH;
                  bus.in_ready <= 1'b0;
                end
              end
            endcase
          end
        end
        FLUSH: begin
          state      <= DONE;
          done       <= 1'b1;
          fetch_hold <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads with random data/throttling
// compared against an expected-write list derived from the framing rules.
module tb_imem_loader;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          fetch_hold;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .fetch_hold   (fetch_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         wr_q[$];
  int          we_cyc_q[$];
  logic [7:0]  stream_q[$];
  logic [31:0] words[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc = 0;
  int          last_we_cyc = -1;
  int          done_rise_cyc = -1;
  int          fh_fall_cyc = -1;
  logic        done_q = 1'b0;
  logic        fh_q   = 1'b1;

  // Write/edge monitor, sampled mid-cycle
  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (bus.mem_we === 1'b1) begin
      w.addr = bus.mem_waddr;
      w.data = bus.mem_wdata;
      wr_q.push_back(w);
      we_cyc_q.push_back(cyc);
      last_we_cyc = cyc;
    end
    if (done === 1'b1 && done_q !== 1'b1) done_rise_cyc = cyc;
    if (fetch_hold === 1'b0 && fh_q !== 1'b0) fh_fall_cyc = cyc;
    done_q = done;
    fh_q   = fetch_hold;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_q.delete();
    we_cyc_q.delete();
    last_we_cyc   = -1;
    done_rise_cyc = -1;
    fh_fall_cyc   = -1;
  endtask

  task automatic build(input int unsigned cnt, input int unsigned nw, input bit rnd,
                       input logic [31:0] base);
    stream_q.delete();
    words.delete();
    stream_q.push_back(8'(cnt));
    stream_q.push_back(8'(cnt >> 8));
    for (int i = 0; i < int'(nw); i++) begin
      logic [31:0] w;
      w = rnd ? 32'($urandom) : base + 32'(i);
      words.push_back(w);
      for (int b = 0; b < 4; b++) stream_q.push_back(8'(w >> (8 * b)));
    end
  endtask

  task automatic pulse_start(input bit stray);
    start        = 1'b1;
    bus.in_valid = stray;
    bus.in_data  = 8'hAA;
    @(posedge clk); #1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  // Feeds the first nbytes of stream_q; in_ready must hold high while bytes remain
  task automatic send(input int nbytes, input bit throttle, input int start_at);
    int idx = 0;
    int guard = 0;
    bit acc;
    bit pulsed = 1'b0;
    while (idx < nbytes && guard < 5000) begin
      bus.in_valid = throttle ? 1'($urandom & 1) : 1'b1;
      bus.in_data  = stream_q[idx];
      start        = (idx == start_at) && !pulsed;
      if (start) pulsed = 1'b1;
      chk("in_ready_rx", bus.in_ready, 1);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    chk("bytes_accepted", idx, nbytes);
  endtask

  task automatic run_load(input string tag, input int unsigned cnt, input bit throttle,
                          input int start_at);
    int exp_n;
    clear_mon();
    send(stream_q.size(), throttle, start_at);
    if (cnt == 0) begin
      chk({tag, "_hdr_done"}, done, 1);
      chk({tag, "_hdr_hold"}, fetch_hold, 0);
    end else if (cnt > DEPTH) begin
      chk({tag, "_hdr_err"}, err, 1);
      chk({tag, "_hdr_hold"}, fetch_hold, 1);
    end else begin
      chk({tag, "_flush_we"}, bus.mem_we, 1);
      chk({tag, "_flush_addr"}, bus.mem_waddr, cnt - 1);
      chk({tag, "_flush_done"}, done, 0);
    end
    chk({tag, "_rdy_after"}, bus.in_ready, 0);
    repeat (4) @(posedge clk);
    #1;
    exp_n = (cnt >= 1 && cnt <= DEPTH) ? int'(cnt) : 0;
    chk({tag, "_nwrites"}, wr_q.size(), exp_n);
    for (int i = 0; i < wr_q.size() && i < exp_n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, i);
      chk($sformatf("%s_data%0d", tag, i), wr_q[i].data, words[i]);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), (we_cyc_q[i] - we_cyc_q[i-1]) >= 4, 1);
    end
    chk({tag, "_done"}, done, cnt <= DEPTH);
    chk({tag, "_err"}, err, cnt > DEPTH);
    chk({tag, "_fetch_hold"}, fetch_hold, cnt > DEPTH);
    chk({tag, "_words_loaded"}, words_loaded, exp_n);
    if (exp_n > 0) begin
      chk({tag, "_done_lat"}, done_rise_cyc, last_we_cyc + 1);
      chk({tag, "_hold_fall"}, fh_fall_cyc, done_rise_cyc);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset values
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_waddr", bus.mem_waddr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_fetch_hold", fetch_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_words_loaded", words_loaded, 0);

    // reset in the middle of a 3-word load
    build(3, 3, 1'b1, 32'h0);
    pulse_start(1'b0);
    clear_mon();
    send(6, 1'b0, -1);
    chk("mid_we_before_rst", bus.mem_we, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we", bus.mem_we, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_waddr", bus.mem_waddr, 0);
    chk("mid_rst_wdata", bus.mem_wdata, 0);
    chk("mid_rst_hold", fetch_hold, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_words", words_loaded, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_writes", wr_q.size(), 0);
    build(3, 3, 1'b1, 32'h0);
    pulse_start(1'b0);
    run_load("reload", 3, 1'b0, -1);

    // basic load
    build(5, 5, 1'b0, 32'hE3A0_0001);
    pulse_start(1'b0);
    run_load("basic", 5, 1'b0, -1);

    // throttled source, same image
    build(5, 5, 1'b0, 32'hE3A0_0001);
    pulse_start(1'b0);
    run_load("throttle", 5, 1'b1, -1);

    // random sizes and data, throttled
    for (int r = 0; r < 3; r++) begin
      int unsigned n;
      n = $urandom_range(12, 1);
      build(n, n, 1'b1, 32'h0);
      pulse_start(1'b0);
      run_load($sformatf("rand%0d", r), n, 1'b1, -1);
    end

    // re-arm from DONE with a stray byte present, then header-only image
    build(0, 0, 1'b0, 32'h0);
    pulse_start(1'b1);
    chk("rearm_done", done, 0);
    chk("rearm_hold", fetch_hold, 1);
    chk("rearm_in_ready", bus.in_ready, 1);
    chk("rearm_words", words_loaded, 0);
    run_load("count0", 0, 1'b0, -1);

    // oversize header
    build(DEPTH + 1, 0, 1'b0, 32'h0);
    pulse_start(1'b0);
    run_load("oversize", DEPTH + 1, 1'b0, -1);

    // full-depth image from ERR, with an ignored start mid-DATA
    build(DEPTH, DEPTH, 1'b1, 32'h0);
    pulse_start(1'b0);
    chk("from_err_err", err, 0);
    run_load("full", DEPTH, 1'b0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
